// File: rtl/n64adv2_ctrl_evtgen_pkg.sv
// Shared event encoding, source code indices and axis helpers for the
// controller event generator.
package n64adv2_ctrl_evtgen_pkg;

  localparam int EVT_WIDTH = 7;
  localparam int SRC_NUM   = 18;

  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;
  localparam logic [1:0] EVT_REPEAT  = 2'b11;

  localparam logic [4:0] SRC_A     = 5'd0;
  localparam logic [4:0] SRC_DU    = 5'd4;
  localparam logic [4:0] SRC_L     = 5'd8;
  localparam logic [4:0] SRC_RIGHT = 5'd14;
  localparam logic [4:0] SRC_LEFT  = 5'd15;
  localparam logic [4:0] SRC_UP    = 5'd16;
  localparam logic [4:0] SRC_DOWN  = 5'd17;
  localparam logic [4:0] SRC_LAST  = SRC_DOWN;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_REPT = 2'd2
  } evt_state_e;

  // The first bit on the wire is the MSB of the axis byte.
  function automatic logic [7:0] axis_from_wire(input logic [7:0] wire_bits);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = wire_bits[i];
    return r;
  endfunction

endpackage

// File: rtl/n64adv2_evt_fifo.sv
// Synchronous first-word-fall-through FIFO; head data is valid whenever
// o_valid is high. Writer must not push when full unless it pops in the same cycle.
module n64adv2_evt_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop;

  assign o_valid = (r_wr_ptr != r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop   = i_pop && o_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/n64adv2_ctrl_evtgen.sv
// Turns sniffed controller polls into a queued press/release/repeat event
// stream and raises a one-shot pulse when a button combo is held long enough.
module n64adv2_ctrl_evtgen
  import n64adv2_ctrl_evtgen_pkg::*;
#(
  parameter int                FIFO_DEPTH   = 8,
  parameter logic signed [7:0] STICK_THRES  = 8'sd40,
  parameter logic [5:0]        REPEAT_DELAY = 6'd20,
  parameter logic [5:0]        REPEAT_RATE  = 6'd4,
  parameter logic [5:0]        HOLD_POLLS   = 6'd30,
  parameter logic [15:0]       COMBO        = 16'h0000
) (
  input  logic                 CTRL_CLK,
  input  logic                 CTRL_nRST,
  input  logic [31:0]          ctrl_data_i,
  input  logic                 ctrl_valid_i,
  output logic                 evt_valid_o,
  output logic [EVT_WIDTH-1:0] evt_data_o,
  input  logic                 evt_ready_i,
  output logic                 combo_hit_o,
  output logic [7:0]           drop_cnt_o,
  output logic [1:0]           dbg_state_o
);

  // Event handshake: the head entry transfers on any clock edge where
  // evt_valid_o and evt_ready_i are both high; evt_data_o is stable while
  // evt_valid_o is high and not popped.
  localparam logic signed [7:0] NEG_THRES = -STICK_THRES;

  evt_state_e          r_state;
  logic [4:0]          r_idx;
  logic [SRC_NUM-1:0]  r_cur;
  logic [SRC_NUM-1:0]  r_prev;
  logic [SRC_NUM-1:0]  r_pend_src;
  logic                r_pend_vld;
  logic                r_new_any;
  logic [4:0]          r_new_hi;
  logic [4:0]          r_rpt_src;
  logic [5:0]          r_rpt_cnt;
  logic [5:0]          r_hold_cnt;

  logic signed [7:0]   w_x;
  logic signed [7:0]   w_y;
  logic [SRC_NUM-1:0]  w_src;
  logic                w_cur_bit;
  logic                w_scan_evt;
  logic                w_rpt_held;
  logic [5:0]          w_rpt_next;
  logic                w_rpt_due;
  logic                w_full;
  logic                w_can_push;
  logic                w_stall;
  logic                w_push;
  logic [EVT_WIDTH-1:0] w_push_data;
  logic [5:0]          w_hold_next;

  assign w_x   = axis_from_wire(ctrl_data_i[23:16]);
  assign w_y   = axis_from_wire(ctrl_data_i[31:24]);
  assign w_src = {w_y < NEG_THRES, w_y > STICK_THRES, w_x < NEG_THRES, w_x > STICK_THRES,
                  ctrl_data_i[15:10], ctrl_data_i[7:0]};

  assign w_cur_bit  = r_cur[r_idx];
  assign w_scan_evt = (r_state == ST_SCAN) && (w_cur_bit != r_prev[r_idx]);

  // Held means set in both the previous and the current poll.
  assign w_rpt_held = r_cur[r_rpt_src] & r_prev[r_rpt_src];
  assign w_rpt_next = r_rpt_cnt + 6'd1;
  assign w_rpt_due  = (r_state == ST_REPT) && !r_new_any && w_rpt_held &&
                      (w_rpt_next == REPEAT_DELAY);

  assign w_can_push  = !w_full || evt_ready_i;
  assign w_stall     = (w_scan_evt || w_rpt_due) && !w_can_push;
  assign w_push      = (w_scan_evt || w_rpt_due) && w_can_push;
  assign w_push_data = w_rpt_due ? {EVT_REPEAT, r_rpt_src}
                                 : {(w_cur_bit ? EVT_PRESS : EVT_RELEASE), r_idx};
  assign w_hold_next = r_hold_cnt + 6'd1;
  assign dbg_state_o = r_state;

  n64adv2_evt_fifo #(
    .WIDTH (EVT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CTRL_CLK),
    .i_rst_n (CTRL_nRST),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (evt_ready_i),
    .o_full  (w_full),
    .o_valid (evt_valid_o),
    .o_data  (evt_data_o)
  );

  always_ff @(posedge CTRL_CLK or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_cur      <= '0;
      r_prev     <= '0;
      r_pend_src <= '0;
      r_pend_vld <= 1'b0;
      r_new_any  <= 1'b0;
      r_new_hi   <= '0;
      r_rpt_src  <= '0;
      r_rpt_cnt  <= '0;
      drop_cnt_o <= '0;
    end else begin
      // A poll arriving while busy (or while an older one still waits) parks here.
      if (ctrl_valid_i && (r_state != ST_IDLE || r_pend_vld)) begin
        r_pend_src <= w_src;
        r_pend_vld <= 1'b1;
        if (r_state != ST_IDLE && r_pend_vld && drop_cnt_o != 8'hFF)
          drop_cnt_o <= drop_cnt_o + 8'd1;
      end else if (r_state == ST_IDLE) begin
        r_pend_vld <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_pend_vld || ctrl_valid_i) begin
            r_cur     <= r_pend_vld ? r_pend_src : w_src;
            r_idx     <= '0;
            r_new_any <= 1'b0;
            r_state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!w_stall) begin
            if (w_scan_evt && w_cur_bit) begin
              r_new_any <= 1'b1;
              r_new_hi  <= r_idx;
            end
            if (r_idx == SRC_LAST) r_state <= ST_REPT;
            else                   r_idx   <= r_idx + 5'd1;
          end
        end
        ST_REPT: begin
          if (!w_stall) begin
            if (r_new_any) begin
              r_rpt_src <= r_new_hi;
              r_rpt_cnt <= '0;
            end else if (w_rpt_held) begin
              r_rpt_cnt <= w_rpt_due ? (REPEAT_DELAY - REPEAT_RATE) : w_rpt_next;
            end else begin
              r_rpt_cnt <= '0;
            end
            r_prev  <= r_cur;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Combo tracking sees every strobe directly; the counter parks at
  // HOLD_POLLS so only the first qualifying poll fires.
  always_ff @(posedge CTRL_CLK or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      r_hold_cnt  <= '0;
      combo_hit_o <= 1'b0;
    end else begin
      combo_hit_o <= 1'b0;
      if (ctrl_valid_i) begin
        if (ctrl_data_i[15:0] == COMBO) begin
          if (r_hold_cnt != HOLD_POLLS) begin
            r_hold_cnt <= w_hold_next;
            if (w_hold_next == HOLD_POLLS) combo_hit_o <= 1'b1;
          end
        end else begin
          r_hold_cnt <= '0;
        end
      end
    end
  end

endmodule
